// File: rtl/mdu_pkg.sv
// Shared types, latencies and funct3 encodings for the multi-cycle mul/div issue controller.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_WB = 2'd2
    } mdu_state_e;

    localparam int MUL_LAT    = 3;
    localparam int DIV_LAT    = 33;
    localparam int STARVE_MAX = 4;

    localparam int CNT_W  = 6;
    localparam int WAIT_W = 3;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] op);
        logic [CNT_W-1:0] lat;
        case (op)
            F3_DIV, F3_DIVU, F3_REM, F3_REMU: lat = CNT_W'(DIV_LAT);
            default:                          lat = CNT_W'(MUL_LAT);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/mdu_starve_timer.sv
// Counts consecutive denied writeback cycles and flags starvation so the core inserts bubbles.
module mdu_starve_timer
    import mdu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic denied_i,
    output logic starve_o
);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = '0;
        if (denied_i) begin
            wait_cnt_d = (wait_cnt_q < WAIT_W'(STARVE_MAX)) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;
        end
    end

    // The current denied cycle counts toward the limit, so the bubble starts on the limit-th denial.
    assign starve_o = denied_i && (wait_cnt_q >= WAIT_W'(STARVE_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/writeback controller: latency timing, 1-entry rd scoreboard, WB port arbitration, stalls.
// Optional define MDU_FORWARD_EN forwards the waiting result to ID instead of stalling on RAW.
module mdu_issue_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid_ID,
    input  logic [2:0]  issue_op_ID,
    input  logic [4:0]  rd_ID,
    input  logic        rduse_ID,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1use_ID,
    input  logic        rs2use_ID,
    input  logic        flush_ID,
    input  logic        reg_write_WB,
    input  logic [31:0] mdu_result,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic        mdu_stall_ID,
    output logic        mdu_wb_en,
    output logic [4:0]  mdu_wb_rd,
    output logic [31:0] mdu_wb_data,
    output logic        mdu_fwd_A,
    output logic        mdu_fwd_B
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       pend_rd_q, pend_rd_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      res_q, res_d;

    logic in_wait, wb_grant, denied, starve;
    logic hit_rs1, hit_rs2, hit_rd, structural, raw_stall, accept;

    assign in_wait  = (state_q == WAIT_WB);
    assign wb_grant = in_wait && !reg_write_WB;
    assign denied   = in_wait && reg_write_WB;

    mdu_starve_timer u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .denied_i (denied),
        .starve_o (starve)
    );

    assign hit_rs1    = pend_valid_q && rs1use_ID && (rs1_ID == pend_rd_q);
    assign hit_rs2    = pend_valid_q && rs2use_ID && (rs2_ID == pend_rd_q);
    assign hit_rd     = pend_valid_q && rduse_ID && (rd_ID == pend_rd_q);
    assign structural = issue_valid_ID && (state_q != IDLE) && !wb_grant;

`ifdef MDU_FORWARD_EN
    assign raw_stall   = (hit_rs1 || hit_rs2) && !in_wait;
    assign mdu_fwd_A   = hit_rs1 && in_wait;
    assign mdu_fwd_B   = hit_rs2 && in_wait;
    assign mdu_wb_data = in_wait ? res_q : 32'd0;
`else
    assign raw_stall   = hit_rs1 || hit_rs2;
    assign mdu_fwd_A   = 1'b0;
    assign mdu_fwd_B   = 1'b0;
    assign mdu_wb_data = wb_grant ? res_q : 32'd0;
`endif

    assign mdu_stall_ID = structural || raw_stall || hit_rd || starve;
    assign accept       = issue_valid_ID && !mdu_stall_ID && !flush_ID;

    // Op is presented with the start pulse and then held from the register through EXEC.
    assign mdu_start = accept;
    assign mdu_op    = accept ? issue_op_ID : op_q;
    assign mdu_wb_en = wb_grant;
    assign mdu_wb_rd = wb_grant ? pend_rd_q : 5'd0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        pend_rd_d    = pend_rd_q;
        pend_valid_d = pend_valid_q;
        res_d        = res_q;
        case (state_q)
            EXEC: begin
                if (cnt_q == '0) begin
                    res_d   = mdu_result;
                    state_d = pend_valid_q ? WAIT_WB : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_WB: begin
                if (wb_grant) begin
                    pend_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: ;
        endcase
        // Acceptance is only possible from IDLE or a granted WAIT_WB, so it overrides both.
        if (accept) begin
            state_d      = EXEC;
            cnt_d        = lat_of(issue_op_ID) - CNT_W'(1);
            op_d         = issue_op_ID;
            pend_rd_d    = rd_ID;
            pend_valid_d = (rd_ID != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            pend_rd_q    <= '0;
            pend_valid_q <= 1'b0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            pend_rd_q    <= pend_rd_d;
            pend_valid_q <= pend_valid_d;
            res_q        <= res_d;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: latency, scoreboard stalls, starvation, chained issue, reset.
module tb_mdu_issue_ctrl;

`ifdef MDU_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid_ID;
    logic [2:0]  issue_op_ID;
    logic [4:0]  rd_ID;
    logic        rduse_ID;
    logic [4:0]  rs1_ID, rs2_ID;
    logic        rs1use_ID, rs2use_ID;
    logic        flush_ID;
    logic        reg_write_WB;
    logic [31:0] mdu_result;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic        mdu_stall_ID;
    logic        mdu_wb_en;
    logic [4:0]  mdu_wb_rd;
    logic [31:0] mdu_wb_data;
    logic        mdu_fwd_A, mdu_fwd_B;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid_ID (issue_valid_ID),
        .issue_op_ID    (issue_op_ID),
        .rd_ID          (rd_ID),
        .rduse_ID       (rduse_ID),
        .rs1_ID         (rs1_ID),
        .rs2_ID         (rs2_ID),
        .rs1use_ID      (rs1use_ID),
        .rs2use_ID      (rs2use_ID),
        .flush_ID       (flush_ID),
        .reg_write_WB   (reg_write_WB),
        .mdu_result     (mdu_result),
        .mdu_start      (mdu_start),
        .mdu_op         (mdu_op),
        .mdu_stall_ID   (mdu_stall_ID),
        .mdu_wb_en      (mdu_wb_en),
        .mdu_wb_rd      (mdu_wb_rd),
        .mdu_wb_data    (mdu_wb_data),
        .mdu_fwd_A      (mdu_fwd_A),
        .mdu_fwd_B      (mdu_fwd_B)
    );

    task automatic applyStimulus(input logic iv, input logic [2:0] op, input logic [4:0] rd,
                                 input logic rdu, input logic [4:0] r1, input logic r1u,
                                 input logic [4:0] r2, input logic r2u, input logic fl,
                                 input logic rw, input logic [31:0] res);
        issue_valid_ID = iv;
        issue_op_ID    = op;
        rd_ID          = rd;
        rduse_ID       = rdu;
        rs1_ID         = r1;
        rs1use_ID      = r1u;
        rs2_ID         = r2;
        rs2use_ID      = r2u;
        flush_ID       = fl;
        reg_write_WB   = rw;
        mdu_result     = res;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleOutputs();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        repeat (2) nextCycle();
        sampleOutputs();
        checkOutput("rst_start", mdu_start, 0);
        checkOutput("rst_op", mdu_op, 0);
        checkOutput("rst_stall", mdu_stall_ID, 0);
        checkOutput("rst_wb_en", mdu_wb_en, 0);
        checkOutput("rst_wb_rd", mdu_wb_rd, 0);
        checkOutput("rst_wb_data", mdu_wb_data, 0);
        checkOutput("rst_fwd_A", mdu_fwd_A, 0);
        checkOutput("rst_fwd_B", mdu_fwd_B, 0);
        nextCycle();
        rst_n = 1'b1;

        // MUL x5: start in cycle 0, writeback in cycle 4
        applyStimulus(1, 3'b000, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("mul_start", mdu_start, 1);
        checkOutput("mul_stall_c0", mdu_stall_ID, 0);
        nextCycle();
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(0, 3'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, (c == 3) ? 32'hDEAD0005 : 32'h0BAD0000);
            sampleOutputs();
            checkOutput($sformatf("mul_start_c%0d", c), mdu_start, 0);
            checkOutput($sformatf("mul_wb_en_c%0d", c), mdu_wb_en, (c == 4));
            checkOutput($sformatf("mul_wb_rd_c%0d", c), mdu_wb_rd, (c == 4) ? 5 : 0);
            checkOutput($sformatf("mul_wb_data_c%0d", c), mdu_wb_data, (c == 4) ? 32'hDEAD0005 : 32'h0);
            nextCycle();
        end

        // DIV x7 followed by a reader of x7
        applyStimulus(1, 3'b100, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("div_start", mdu_start, 1);
        checkOutput("div_op_c0", mdu_op, 4);
        nextCycle();
        for (int c = 1; c <= 35; c++) begin
            applyStimulus(0, 3'd0, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0, (c == 33) ? 32'h00C0FFEE : 32'h0BAD0000);
            sampleOutputs();
            checkOutput($sformatf("div_stall_c%0d", c), mdu_stall_ID, FWD ? (c <= 33) : (c <= 34));
            checkOutput($sformatf("div_fwd_A_c%0d", c), mdu_fwd_A, FWD && (c == 34));
            checkOutput($sformatf("div_wb_en_c%0d", c), mdu_wb_en, (c == 34));
            checkOutput($sformatf("div_wb_data_c%0d", c), mdu_wb_data, (c == 34) ? 32'h00C0FFEE : 32'h0);
            nextCycle();
        end

        // MUL x3 with WAW reader, then WB port busy for 6 cycles
        applyStimulus(1, 3'b000, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("starve_start", mdu_start, 1);
        nextCycle();
        for (int c = 1; c <= 11; c++) begin
            applyStimulus(0, 3'd0, 5'd3, (c <= 2), 5'd0, 0, 5'd0, 0, 0, (c >= 4 && c <= 9),
                          (c == 3) ? 32'h00000033 : 32'h0BAD0000);
            sampleOutputs();
            checkOutput($sformatf("starve_stall_c%0d", c), mdu_stall_ID, (c <= 2) || (c >= 7 && c <= 9));
            checkOutput($sformatf("starve_wb_en_c%0d", c), mdu_wb_en, (c == 10));
            checkOutput($sformatf("starve_wb_rd_c%0d", c), mdu_wb_rd, (c == 10) ? 3 : 0);
            checkOutput($sformatf("starve_wb_data_c%0d", c), mdu_wb_data, (c == 10) ? 32'h33 : 32'h0);
            nextCycle();
        end

        // MULH to x0: no writeback, x0 readers never stall, IDLE again after 3 EXEC cycles
        applyStimulus(1, 3'b001, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("x0_start", mdu_start, 1);
        checkOutput("x0_op", mdu_op, 1);
        nextCycle();
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 3'd0, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 32'h0BAD0000);
            sampleOutputs();
            checkOutput($sformatf("x0_stall_c%0d", c), mdu_stall_ID, 0);
            checkOutput($sformatf("x0_wb_en_c%0d", c), mdu_wb_en, 0);
            nextCycle();
        end
        applyStimulus(1, 3'b000, 5'd9, 1, 5'd0, 1, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("x0_reissue_start", mdu_start, 1);
        checkOutput("x0_reissue_stall", mdu_stall_ID, 0);
        checkOutput("x0_reissue_wb_en", mdu_wb_en, 0);
        nextCycle();

        // MUL x9 then a MULHU x10 arriving in the grant cycle
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 3'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, (c == 3) ? 32'h00000099 : 32'h0BAD0000);
            sampleOutputs();
            checkOutput($sformatf("chain_wb_en_c%0d", c), mdu_wb_en, 0);
            nextCycle();
        end
        applyStimulus(1, 3'b011, 5'd10, 1, 5'd1, 1, 5'd2, 1, 0, 0, 32'h0BAD0000);
        sampleOutputs();
        checkOutput("chain_grant_wb_en", mdu_wb_en, 1);
        checkOutput("chain_grant_wb_rd", mdu_wb_rd, 9);
        checkOutput("chain_grant_wb_data", mdu_wb_data, 32'h99);
        checkOutput("chain_grant_start", mdu_start, 1);
        checkOutput("chain_grant_stall", mdu_stall_ID, 0);
        checkOutput("chain_grant_op", mdu_op, 3);
        nextCycle();
        applyStimulus(1, 3'b100, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0BAD0000);
        sampleOutputs();
        checkOutput("struct_stall", mdu_stall_ID, 1);
        checkOutput("struct_start", mdu_start, 0);
        checkOutput("struct_op_held", mdu_op, 3);
        checkOutput("struct_wb_en", mdu_wb_en, 0);
        nextCycle();
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(0, 3'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, (c == 3) ? 32'h000000AA : 32'h0BAD0000);
            sampleOutputs();
            checkOutput($sformatf("chain2_wb_en_c%0d", c), mdu_wb_en, (c == 4));
            checkOutput($sformatf("chain2_wb_rd_c%0d", c), mdu_wb_rd, (c == 4) ? 10 : 0);
            checkOutput($sformatf("chain2_wb_data_c%0d", c), mdu_wb_data, (c == 4) ? 32'hAA : 32'h0);
            nextCycle();
        end

        // Flushed issue is dropped
        applyStimulus(1, 3'b000, 5'd4, 1, 5'd0, 0, 5'd0, 0, 1, 0, 32'h0);
        sampleOutputs();
        checkOutput("flush_start", mdu_start, 0);
        nextCycle();
        applyStimulus(0, 3'd0, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("flush_no_pending", mdu_stall_ID, 0);
        nextCycle();

        // Reset in cycle 10 of a DIVU to x12, then a fresh MUL x13
        applyStimulus(1, 3'b101, 5'd12, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("rdiv_start", mdu_start, 1);
        nextCycle();
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(0, 3'd0, 5'd0, 0, 5'd12, 1, 5'd0, 0, 0, 0, 32'h0BAD0000);
            nextCycle();
        end
        applyStimulus(0, 3'd0, 5'd0, 0, 5'd12, 1, 5'd0, 0, 0, 0, 32'h0BAD0000);
        sampleOutputs();
        checkOutput("rdiv_stall_pre", mdu_stall_ID, 1);
        checkOutput("rdiv_op_pre", mdu_op, 5);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rdiv_stall_post", mdu_stall_ID, 0);
        checkOutput("rdiv_op_post", mdu_op, 0);
        checkOutput("rdiv_wb_en_post", mdu_wb_en, 0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1, 3'b000, 5'd13, 1, 5'd0, 0, 5'd0, 0, 0, 0, 32'h0);
        sampleOutputs();
        checkOutput("rmul_start", mdu_start, 1);
        checkOutput("rmul_stall", mdu_stall_ID, 0);
        nextCycle();
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(0, 3'd0, 5'd0, 0, 5'd12, 1, 5'd0, 0, 0, 0, (c == 3) ? 32'h00001313 : 32'h0BAD0000);
            sampleOutputs();
            checkOutput($sformatf("rmul_stall_c%0d", c), mdu_stall_ID, 0);
            checkOutput($sformatf("rmul_wb_en_c%0d", c), mdu_wb_en, (c == 4));
            checkOutput($sformatf("rmul_wb_rd_c%0d", c), mdu_wb_rd, (c == 4) ? 13 : 0);
            checkOutput($sformatf("rmul_wb_data_c%0d", c), mdu_wb_data, (c == 4) ? 32'h1313 : 32'h0);
            nextCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
